cache_perf_monitor: RTL and testbench



---
 rtl/cache_perf_monitor_if.sv | 31 +++
 rtl/cache_perf_monitor.sv | 118 +++++++++++
 tb/tb_cache_perf_monitor.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_perf_monitor_if.sv
// Processor-to-cache snoop bus and performance-counter results for
// cache_perf_monitor. The master side drives the handshake and reads the
// counters; the slave side is the monitor itself.
interface cache_perf_monitor_if #(
    parameter int unsigned CW = 51,
    parameter int unsigned LW = 16
);
    logic          start;
    logic          stop;
    logic          proc_read;
    logic          proc_write;
    logic          proc_stall;
    logic [29:0]   proc_addr;
    logic [31:0]   proc_wdata;
    logic [CW-1:0] hittime;
    logic [CW-1:0] totaltime;
    logic [CW-1:0] stallcycle;
    logic [CW-1:0] miss_cnt;
    logic [LW-1:0] max_miss_lat;
    logic          running;

    modport master (
        output start, stop, proc_read, proc_write, proc_stall, proc_addr, proc_wdata,
        input  hittime, totaltime, stallcycle, miss_cnt, max_miss_lat, running
    );

    modport slave (
        input  start, stop, proc_read, proc_write, proc_stall, proc_addr, proc_wdata,
        output hittime, totaltime, stallcycle, miss_cnt, max_miss_lat, running
    );
endinterface

// File: rtl/cache_perf_monitor.sv
// Cache performance monitor: snoops the processor/cache handshake between a
// start (arm) event and a stop event, accumulating hits, run cycles, stall
// cycles, misses and the worst single miss latency. All counters saturate.
// Optional macro PERF_SNOOP_START_EN: arm on a write of BEGIN_SYMBOL to
// TEST_PORT instead of the start pulse.
module cache_perf_monitor #(
    parameter int unsigned CW           = 51,
    parameter int unsigned LW           = 16,
    parameter logic [29:0] TEST_PORT    = 30'hFF,
    parameter logic [31:0] BEGIN_SYMBOL = 32'h00000932
) (
    input logic                 clk,
    input logic                 rst,
    cache_perf_monitor_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FROZEN = 2'd2;

    localparam logic A_IDLE  = 1'b0;
    localparam logic A_STALL = 1'b1;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [LW-1:0] LAT_MAX = '1;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          a_state;
    logic [LW-1:0] lat;
    logic          arm;
    logic          req;

`ifdef PERF_SNOOP_START_EN
    logic unused_start;
    assign unused_start = bus.start;
    assign arm = bus.proc_write && (bus.proc_addr == TEST_PORT) &&
                 (bus.proc_wdata == BEGIN_SYMBOL) && !bus.proc_stall;
`else
    logic unused_snoop;
    assign unused_snoop = ^{bus.proc_addr, bus.proc_wdata};
    assign arm = bus.start;
`endif

    assign req = bus.proc_read | bus.proc_write;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Run FSM next state: IDLE arms to RUN, RUN freezes on stop, FROZEN is terminal
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arm) state_nxt = RUN;
            RUN:     if (bus.stop) state_nxt = FROZEN;
            default: state_nxt = state;
        endcase
    end

    // Run FSM state and running flag; running tracks the registered state exactly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bus.running <= 1'b0;
        end else begin
            state       <= state_nxt;
            bus.running <= (state_nxt == RUN);
        end
    end

    // Cycle and stall-cycle accounting for every RUN cycle, stop cycle included
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.totaltime  <= '0;
            bus.stallcycle <= '0;
        end else if (state == RUN) begin
            bus.totaltime <= sat_inc(bus.totaltime);
            if (bus.proc_stall) bus.stallcycle <= sat_inc(bus.stallcycle);
        end
    end

    // Access FSM: classifies each request as hit or miss and times stall bursts.
    // A burst still open when RUN ends is dropped because the FSM is forced idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_state          <= A_IDLE;
            lat              <= '0;
            bus.hittime      <= '0;
            bus.miss_cnt     <= '0;
            bus.max_miss_lat <= '0;
        end else if (state != RUN) begin
            a_state <= A_IDLE;
            lat     <= '0;
        end else begin
            case (a_state)
                A_IDLE: begin
                    if (req) begin
                        if (!bus.proc_stall) begin
                            bus.hittime <= sat_inc(bus.hittime);
                        end else begin
                            bus.miss_cnt <= sat_inc(bus.miss_cnt);
                            lat          <= LW'(1);
                            a_state      <= A_STALL;
                        end
                    end
                end
                default: begin
                    if (bus.proc_stall) begin
                        if (lat != LAT_MAX) lat <= lat + 1'b1;
                    end else begin
                        if (lat > bus.max_miss_lat) bus.max_miss_lat <= lat;
                        a_state <= A_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_perf_monitor.sv
// Directed scoreboard bench for cache_perf_monitor: a full-width instance and
// a narrow instance (CW=4, LW=3) used to reach saturation quickly.
module tb_cache_perf_monitor;
    logic clk;
    logic rst;
    logic rst_s;

    cache_perf_monitor_if #(.CW(51), .LW(16)) bus ();
    cache_perf_monitor_if #(.CW(4),  .LW(3))  bus_s ();

    cache_perf_monitor #(.CW(51), .LW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cache_perf_monitor #(.CW(4), .LW(3)) dut_s (
        .clk (clk),
        .rst (rst_s),
        .bus (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          sel;
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [63:0] observe(input bit sel, input string tag);
        logic [63:0] r;
        r = '1;
        if (!sel) begin
            case (tag)
                "hittime":      r = 64'(bus.hittime);
                "totaltime":    r = 64'(bus.totaltime);
                "stallcycle":   r = 64'(bus.stallcycle);
                "miss_cnt":     r = 64'(bus.miss_cnt);
                "max_miss_lat": r = 64'(bus.max_miss_lat);
                "running":      r = 64'(bus.running);
                default:        r = '1;
            endcase
        end else begin
            case (tag)
                "hittime":      r = 64'(bus_s.hittime);
                "totaltime":    r = 64'(bus_s.totaltime);
                "stallcycle":   r = 64'(bus_s.stallcycle);
                "miss_cnt":     r = 64'(bus_s.miss_cnt);
                "max_miss_lat": r = 64'(bus_s.max_miss_lat);
                "running":      r = 64'(bus_s.running);
                default:        r = '1;
            endcase
        end
        return r;
    endfunction

    task automatic exp_push(input bit sel, input string tag, input logic [63:0] v);
        exp_t e;
        e.sel = sel;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic exp_all(input bit sel, input logic [63:0] hit, input logic [63:0] tot,
                           input logic [63:0] stl, input logic [63:0] mis,
                           input logic [63:0] lat, input logic [63:0] run);
        exp_push(sel, "hittime", hit);
        exp_push(sel, "totaltime", tot);
        exp_push(sel, "stallcycle", stl);
        exp_push(sel, "miss_cnt", mis);
        exp_push(sel, "max_miss_lat", lat);
        exp_push(sel, "running", run);
    endtask

    task automatic check_sb(input string step);
        exp_t        e;
        logic [63:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel, e.tag);
            checks++;
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s/%s dut%0d: observed=%0h expected=%0h", step, e.tag, e.sel, obs, e.val);
            end
        end
    endtask

    // One clock cycle with the given inputs on both buses; returns 1 time unit after the edge.
    task automatic cyc(input logic r, input logic w, input logic s, input logic st,
                       input logic sp, input logic [29:0] a = 30'h0,
                       input logic [31:0] d = 32'h0);
        bus.proc_read    = r;  bus_s.proc_read  = r;
        bus.proc_write   = w;  bus_s.proc_write = w;
        bus.proc_stall   = s;  bus_s.proc_stall = s;
        bus.start        = st; bus_s.start      = st;
        bus.stop         = sp; bus_s.stop       = sp;
        bus.proc_addr    = a;  bus_s.proc_addr  = a;
        bus.proc_wdata   = d;  bus_s.proc_wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic sp);
`ifdef PERF_SNOOP_START_EN
        cyc(1'b0, 1'b1, 1'b0, 1'b0, sp, 30'hFF, 32'h00000932);
`else
        cyc(1'b0, 1'b0, 1'b0, 1'b1, sp);
`endif
    endtask

    // Asynchronous reset of the full-width instance, checked before any clock edge.
    task automatic reset_main(input string step);
        rst = 1'b0;
        #2;
        exp_all(0, 0, 0, 0, 0, 0, 0);
        check_sb(step);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    initial begin
        rst   = 1'b0;
        rst_s = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Idle run: stop in IDLE ignored, arm cycle not counted, stop cycle counted
        reset_main("reset1");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_push(0, "running", 0);
        check_sb("stop_in_idle");
        arm(1'b0);
        exp_push(0, "running", 1);
        exp_push(0, "totaltime", 0);
        check_sb("armed");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (9) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_push(0, "totaltime", 10);
        exp_push(0, "running", 1);
        check_sb("idle10");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_all(0, 0, 11, 0, 0, 0, 0);
        check_sb("idle_stop");
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_push(0, "totaltime", 11);
        check_sb("idle_frozen");

        // Five hits; arm and stop together in IDLE still arms
        reset_main("reset2");
        arm(1'b1);
        exp_push(0, "running", 1);
        check_sb("arm_with_stop");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_all(0, 5, 6, 0, 0, 0, 0);
        check_sb("hits5");

        // Two misses: 7-cycle and 3-cycle stall bursts
        reset_main("reset3");
        arm(1'b0);
        repeat (7) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_push(0, "miss_cnt", 1);
        exp_push(0, "stallcycle", 7);
        exp_push(0, "max_miss_lat", 0);
        check_sb("burst7_open");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_push(0, "max_miss_lat", 7);
        exp_push(0, "hittime", 0);
        exp_push(0, "miss_cnt", 1);
        check_sb("burst7_close");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_all(0, 0, 14, 10, 2, 7, 0);
        check_sb("misses2");

        // Stop inside an open burst discards it; frozen outputs ignore further traffic
        reset_main("reset4");
        arm(1'b0);
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_push(0, "max_miss_lat", 3);
        check_sb("burst3");
        repeat (4) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        exp_all(0, 0, 9, 8, 2, 3, 0);
        check_sb("stop_in_burst");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        arm(1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_all(0, 0, 9, 8, 2, 3, 0);
        check_sb("frozen_hold");

        // Asynchronous reset in the middle of a RUN stall burst
        reset_main("reset5");
        arm(1'b0);
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_push(0, "stallcycle", 3);
        check_sb("pre_async");
        reset_main("async_mid_run");

`ifdef PERF_SNOOP_START_EN
        // Only a stall-free write of the begin symbol to the test port arms
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 30'hFF, 32'h00000931);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 30'hFE, 32'h00000932);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30'hFF, 32'h00000932);
        exp_push(0, "running", 0);
        check_sb("snoop_no_arm");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 30'hFF, 32'h00000932);
        exp_push(0, "running", 1);
        exp_push(0, "totaltime", 0);
        check_sb("snoop_arm");
`else
        // Start pulse arms; a second start in RUN does not restart counting
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_push(0, "running", 1);
        check_sb("start_arm");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_push(0, "totaltime", 2);
        check_sb("start_in_run");
`endif

        // Saturation on the narrow instance (all-ones = 15, latency all-ones = 7)
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_s = 1'b1;
        arm(1'b0);
        repeat (10) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_push(1, "max_miss_lat", 7);
        exp_push(1, "totaltime", 11);
        check_sb("lat_sat");
        repeat (20) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (20) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_push(1, "miss_cnt", 1);
        check_sb("stall_no_req");
        repeat (18) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_all(1, 15, 15, 15, 15, 7, 0);
        check_sb("saturate");
        exp_all(0, 0, 0, 0, 0, 0, 0);
        check_sb("main_held_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
